mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/cpu_bus_pkg.sv | 27 ++
 rtl/arb_timeout_cnt.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter:
// FSM state encoding, owner codes, fetch size code and abort data word.
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_I  = 3'd1,
        GNT_D  = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam logic [2:0]  FETCH_OP   = 3'b010;
    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    // Data side wins unless fetch has been starved long enough and is still asking.
    function automatic owner_t pick_owner(input logic d_req, input logic i_req,
                                          input logic starve_full);
        return (d_req && !(starve_full && i_req)) ? OWNER_D : OWNER_I;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Grant-cycle counter for the arbiter abort path; built only with ARB_TIMEOUT_EN.
// expired is high during the TIMEOUT_CYC-th consecutive active cycle.
module arb_timeout_cnt #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = active && (cnt == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch / load-store) arbiter onto one memory port, with fetch
// anti-starvation. Optional grant timeout abort is enabled by macro ARB_TIMEOUT_EN.
module mem_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int DW          = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [DW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [DW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [2:0]    d_op,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_valid,
    output logic          m_we,
    output logic [DW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [2:0]    m_op,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          gnt_d,
    output logic          bus_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic          starve_full;
    logic          timeout_hit;
    owner_t        winner;

    assign starve_full = (starve_cnt == STARVE_TOP);
    assign winner      = pick_owner(d_req, i_req, starve_full);

`ifdef ARB_TIMEOUT_EN
    logic grant_active;
    assign grant_active = (state == GNT_I) || (state == GNT_D);

    arb_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst    (rst),
        .active (grant_active),
        .expired(timeout_hit)
    );

    // A real m_ack in the final allowed cycle still completes normally.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else begin
            bus_err <= timeout_hit && !m_ack;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit        = 1'b0;
    assign bus_err            = 1'b0;
`endif

    // NOTE: every state register uses <= so each branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            m_valid    <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_op       <= 3'b000;
            gnt_d      <= 1'b0;
            i_ready    <= 1'b0;
            d_ready    <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            i_ready <= 1'b0;
            d_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req || i_req) begin
                        m_valid <= 1'b1;
                        if (winner == OWNER_D) begin
                            state   <= GNT_D;
                            gnt_d   <= 1'b1;
                            m_we    <= d_we;
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            m_op    <= d_op;
                            if (!i_req) begin
                                starve_cnt <= '0;
                            end else if (!starve_full) begin
                                starve_cnt <= starve_cnt + 1'b1;
                            end
                        end else begin
                            state      <= GNT_I;
                            gnt_d      <= 1'b0;
                            m_we       <= 1'b0;
                            m_addr     <= i_addr;
                            m_wdata    <= '0;
                            m_op       <= FETCH_OP;
                            starve_cnt <= '0;
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (m_ack || timeout_hit) begin
                        m_valid <= 1'b0;
                        if (state == GNT_D) begin
                            state   <= RESP_D;
                            d_ready <= 1'b1;
                            if (!m_ack) begin
                                d_rdata <= DW'(ABORT_DATA);
                            end else begin
                                d_rdata <= m_we ? '0 : m_rdata;
                            end
                        end else begin
                            state   <= RESP_I;
                            i_ready <= 1'b1;
                            i_rdata <= m_ack ? m_rdata : DW'(ABORT_DATA);
                        end
                    end
                end
                RESP_I, RESP_D: begin
                    state <= IDLE;
                    gnt_d <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    gnt_d   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_bus_arbiter;

    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int TO_CYC     = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req, d_req, d_we, m_ack;
    logic [DW-1:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [2:0]    d_op;
    logic [DW-1:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic          i_ready, d_ready, m_valid, m_we, gnt_d, bus_err;
    logic [2:0]    m_op;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_op(d_op),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_valid(m_valid), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_op(m_op),
        .m_rdata(m_rdata), .m_ack(m_ack), .gnt_d(gnt_d), .bus_err(bus_err)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction, at most one response cycle.
    bit            model_live = 1'b0;
    bit            busy, resp, own_d;
    int            starve, waited;
    bit            fetch_first;
    logic          e_valid, e_we, e_gnt_d, e_i_ready, e_d_ready, e_bus_err;
    logic [DW-1:0] e_addr, e_wdata, e_i_rdata, e_d_rdata;
    logic [2:0]    e_op;

    task automatic model_finish(input logic [DW-1:0] val, input bit err);
        busy    = 1'b0;
        resp    = 1'b1;
        e_valid = 1'b0;
        e_bus_err = err;
        if (own_d) begin
            e_d_ready = 1'b1;
            e_d_rdata = val;
        end else begin
            e_i_ready = 1'b1;
            e_i_rdata = val;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_live = 1'b1;
            busy = 0; resp = 0; own_d = 0; starve = 0; waited = 0;
            e_valid = 0; e_we = 0; e_gnt_d = 0; e_i_ready = 0; e_d_ready = 0; e_bus_err = 0;
            e_addr = '0; e_wdata = '0; e_i_rdata = '0; e_d_rdata = '0; e_op = '0;
        end else if (model_live) begin
            e_i_ready = 0;
            e_d_ready = 0;
            e_bus_err = 0;
            if (resp) begin
                resp    = 0;
                e_gnt_d = 0;
            end else if (busy) begin
                waited++;
                if (m_ack)
                    model_finish((own_d && e_we) ? '0 : m_rdata, 1'b0);
                else if (TO_ON && waited == TO_CYC)
                    model_finish(32'hDEAD_BEEF, 1'b1);
            end else begin
                fetch_first = i_req && (!d_req || starve == STARVE_MAX);
                if (d_req && !fetch_first) begin
                    busy = 1; own_d = 1; waited = 0;
                    e_valid = 1; e_gnt_d = 1; e_we = d_we;
                    e_addr = d_addr; e_wdata = d_wdata; e_op = d_op;
                    starve = i_req ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
                end else if (i_req) begin
                    busy = 1; own_d = 0; waited = 0;
                    e_valid = 1; e_gnt_d = 0; e_we = 0;
                    e_addr = i_addr; e_op = 3'b010;
                    starve = 0;
                end else begin
                    starve = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("cmp_m_valid", m_valid, e_valid);
            check("cmp_gnt_d",   gnt_d,   e_gnt_d);
            check("cmp_i_ready", i_ready, e_i_ready);
            check("cmp_d_ready", d_ready, e_d_ready);
            check("cmp_bus_err", bus_err, e_bus_err);
            check("cmp_i_rdata", i_rdata, e_i_rdata);
            check("cmp_d_rdata", d_rdata, e_d_rdata);
            if (e_valid) begin
                check("cmp_m_addr", m_addr, e_addr);
                check("cmp_m_we",   m_we,   e_we);
                check("cmp_m_op",   m_op,   e_op);
                if (e_gnt_d) check("cmp_m_wdata", m_wdata, e_wdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for a grant, acks it immediately, and steps past the response cycle.
    task automatic run_txn(input logic [DW-1:0] rdata, output logic was_data);
        int n = 0;
        while (m_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check("txn_grant_seen", m_valid, 1'b1);
        was_data = gnt_d;
        m_ack    = 1'b1;
        m_rdata  = rdata;
        tick();
        m_ack = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    logic was_data;
    logic exp_data;

    initial begin
        rst = 1'b1; i_req = 0; d_req = 0; d_we = 0; m_ack = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; d_op = '0; m_rdata = '0;
        tick(); tick();
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_m_addr",  m_addr,  32'h0);
        rst = 1'b0;

        // Single fetch; request dropped after the grant, ack one cycle after m_valid.
        i_req = 1; i_addr = 32'h100;
        tick();
        i_req = 0;
        check("f_valid", m_valid, 1'b1);
        check("f_addr",  m_addr,  32'h100);
        check("f_op",    m_op,    3'b010);
        tick();
        check("f_we_hold", m_we, 1'b0);
        m_ack = 1; m_rdata = 32'h13;
        tick();
        m_ack = 0;
        check("f_ready", i_ready, 1'b1);
        check("f_rdata", i_rdata, 32'h13);
        tick();
        check("f_ready_drop", i_ready, 1'b0);
        check("f_rdata_hold", i_rdata, 32'h13);

        // A load, so the following store visibly zeroes d_rdata.
        d_req = 1; d_we = 0; d_addr = 32'h500; d_op = 3'b010;
        run_txn(32'h55AA, was_data);
        d_req = 0;
        check("ld_owner", was_data, 1'b1);
        check("ld_rdata", d_rdata, 32'h55AA);

        // Simultaneous fetch and store: data first, then fetch.
        i_req = 1; i_addr = 32'h300;
        d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hA5A5A5A5; d_op = 3'b010;
        tick();
        d_req = 0;
        check("st_gnt_d", gnt_d,   1'b1);
        check("st_wdata", m_wdata, 32'hA5A5A5A5);
        check("st_we",    m_we,    1'b1);
        m_ack = 1; m_rdata = 32'h77;
        tick();
        m_ack = 0;
        check("st_ready", d_ready, 1'b1);
        check("st_rdata", d_rdata, 32'h0);
        tick();
        tick();
        i_req = 0;
        check("st_then_fetch", gnt_d, 1'b0);
        check("st_fetch_addr", m_addr, 32'h300);
        m_ack = 1; m_rdata = 32'h1234;
        tick();
        m_ack = 0;
        check("st_fetch_rdata", i_rdata, 32'h1234);

        // Continuous load pressure with fetch waiting: four data grants, then fetch.
        d_req = 1; d_we = 0; d_addr = 32'h40; d_op = 3'b001; i_req = 1; i_addr = 32'h600;
        for (int k = 0; k < 5; k++) begin
            run_txn(32'h1000 + k, was_data);
            exp_data = (k < 4);
            check($sformatf("starve_grant_%0d", k), was_data, exp_data);
        end
        d_req = 0; i_req = 0;
        check("starve_i_rdata", i_rdata, 32'h1004);
        check("starve_d_rdata", d_rdata, 32'h1003);

        // Stray m_ack while idle changes nothing.
        tick(); tick();
        m_ack = 1; m_rdata = 32'hBAD;
        tick();
        m_ack = 0;
        check("idle_ack_valid",  m_valid, 1'b0);
        check("idle_ack_dready", d_ready, 1'b0);
        check("idle_ack_iready", i_ready, 1'b0);
        check("idle_ack_drdata", d_rdata, 32'h1003);
        tick();
        check("idle_ack_after", d_ready, 1'b0);

        // Reset during a data grant with m_ack pending.
        d_req = 1; d_we = 0; d_addr = 32'h44; d_op = 3'b010;
        tick();
        d_req = 0;
        check("rg_valid", m_valid, 1'b1);
        m_ack = 1; m_rdata = 32'h99; rst = 1;
        tick();
        m_ack = 0; rst = 0;
        check("rg_valid_low", m_valid, 1'b0);
        check("rg_no_ready",  d_ready, 1'b0);
        check("rg_gnt_d",     gnt_d,   1'b0);
        tick();
        check("rg_no_ready2", d_ready, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // Load never acknowledged: abort after TO_CYC grant cycles.
        d_req = 1; d_we = 0; d_addr = 32'h80; d_op = 3'b010;
        tick();
        d_req = 0;
        for (int k = 1; k < TO_CYC; k++) tick();
        check("to_still_valid", m_valid, 1'b1);
        check("to_not_yet",     d_ready, 1'b0);
        tick();
        check("to_ready",   d_ready, 1'b1);
        check("to_bus_err", bus_err, 1'b1);
        check("to_rdata",   d_rdata, 32'hDEADBEEF);
        check("to_valid",   m_valid, 1'b0);
        tick();
        check("to_err_drop", bus_err, 1'b0);
`endif

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
